// File: rtl/tribuf_bus_arbiter.sv
// Round-robin owner selection for a single shared tristate pad.
// One driver at most, idle turnaround between owners, optional hold timeout.
module tribuf_bus_arbiter #(
    parameter int N_REQ      = 4,
    parameter int WIDTH      = 8,
    parameter int TURNAROUND = 1,
    parameter int MAX_HOLD   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] din,
    output logic [N_REQ-1:0]       gnt,
    output logic [2:0]             owner,
    output logic [WIDTH-1:0]       bus_o,
    output logic                   bus_oe,
    output logic                   timeout
);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("tribuf_bus_arbiter: N_REQ must be 2..8");
    end

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        TURN
    } state_t;

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
    localparam logic [3:0] TURN_LD  =
        (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : 4'd0;
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    state_t           state, state_n;
    logic [2:0]       ptr, ptr_n;
    logic [2:0]       owner_n;
    logic [7:0]       hold_cnt, hold_n;
    logic [3:0]       turn_cnt, turn_n;
    logic [N_REQ-1:0] gnt_n;
    logic             timeout_n;
    logic [2:0]       pick;
    logic             pick_vld;
    logic [7:0]       req_pad;
    logic             drop;
    logic             hit;

    assign req_pad = 8'(req);
    assign drop    = !req_pad[owner];
    assign hit     = (MAX_HOLD != 0) && (hold_cnt == HOLD_MAX);

    // First active request at or after the round-robin pointer
    always_comb begin
        int idx;
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!pick_vld && req[idx]) begin
                pick_vld = 1'b1;
                pick     = 3'(idx);
            end
        end
    end

    // Next-state, grant, pointer and counter logic
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        owner_n   = owner;
        hold_n    = hold_cnt;
        turn_n    = turn_cnt;
        gnt_n     = gnt;
        timeout_n = 1'b0;
        unique case (state)
            IDLE: begin
                gnt_n = '0;
                if (pick_vld) begin
                    state_n = OWN;
                    owner_n = pick;
                    hold_n  = 8'd1;
                    gnt_n   = ONE << pick;
                end
            end
            OWN: begin
                if (hold_cnt != 8'hff) begin
                    hold_n = hold_cnt + 8'd1;
                end
                if (drop || hit) begin
                    gnt_n     = '0;
                    timeout_n = hit;
                    ptr_n     = (int'(owner) == N_REQ - 1)
                              ? 3'd0 : owner + 3'd1;
                    if (TURNAROUND == 0) begin
                        state_n = IDLE;
                    end else begin
                        state_n = TURN;
                        turn_n  = TURN_LD;
                    end
                end
            end
            TURN: begin
                gnt_n = '0;
                if (turn_cnt == 4'd0) begin
                    state_n = IDLE;
                end else begin
                    turn_n = turn_cnt - 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    // State and output registers; reset releases the bus on the next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            hold_cnt <= '0;
            turn_cnt <= '0;
            gnt      <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            owner    <= owner_n;
            hold_cnt <= hold_n;
            turn_cnt <= turn_n;
            gnt      <= gnt_n;
            timeout  <= timeout_n;
        end
    end

    assign bus_oe = |gnt;
    assign bus_o  = bus_oe ? din[owner*WIDTH +: WIDTH] : '0;

endmodule

// File: tb/tb_tribuf_bus_arbiter.sv
// Randomized bench for tribuf_bus_arbiter, two configurations side by side.
// Outputs compared each cycle against an ownership-level reference model.
module tb_tribuf_bus_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TA_A = 1;
    localparam int MH_A = 4;
    localparam int TA_B = 0;
    localparam int MH_B = 0;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] din;

    logic [N-1:0] gnt_a, gnt_b;
    logic [2:0]   owner_a, owner_b;
    logic [W-1:0] bus_a, bus_b;
    logic         oe_a, oe_b;
    logic         to_a, to_b;

    int n_chk = 0;
    int n_err = 0;

    // model state per instance: owner (-1 none), cycles held, blocked cycles
    int m_own[2];
    int m_held[2];
    int m_wait[2];
    int m_ptr[2];
    bit m_to[2];
    bit m_rstd[2];

    always #5 clk = ~clk;

    tribuf_bus_arbiter #(
        .N_REQ(N), .WIDTH(W), .TURNAROUND(TA_A), .MAX_HOLD(MH_A)
    ) u_dut_a (
        .clk(clk), .rst(rst), .req(req), .din(din),
        .gnt(gnt_a), .owner(owner_a), .bus_o(bus_a),
        .bus_oe(oe_a), .timeout(to_a)
    );

    tribuf_bus_arbiter #(
        .N_REQ(N), .WIDTH(W), .TURNAROUND(TA_B), .MAX_HOLD(MH_B)
    ) u_dut_b (
        .clk(clk), .rst(rst), .req(req), .din(din),
        .gnt(gnt_b), .owner(owner_b), .bus_o(bus_b),
        .bus_oe(oe_b), .timeout(to_b)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic int ta_of(input int k);
        return (k == 0) ? TA_A : TA_B;
    endfunction

    function automatic int mh_of(input int k);
        return (k == 0) ? MH_A : MH_B;
    endfunction

    task automatic mstep(input int k, input logic r, input logic [N-1:0] rq);
        bit hit;
        bit done;
        int idx;
        m_to[k]   = 1'b0;
        m_rstd[k] = r;
        if (r) begin
            m_own[k]  = -1;
            m_wait[k] = 0;
            m_ptr[k]  = 0;
        end else if (m_own[k] >= 0) begin
            hit = (mh_of(k) != 0) && (m_held[k] == mh_of(k));
            if (!rq[m_own[k]] || hit) begin
                m_to[k]   = hit;
                m_ptr[k]  = (m_own[k] + 1) % N;
                m_own[k]  = -1;
                m_wait[k] = ta_of(k);
            end else begin
                m_held[k]++;
            end
        end else if (m_wait[k] > 0) begin
            m_wait[k]--;
        end else begin
            done = 1'b0;
            for (int i = 0; i < N; i++) begin
                idx = (m_ptr[k] + i) % N;
                if (!done && rq[idx]) begin
                    done      = 1'b1;
                    m_own[k]  = idx;
                    m_held[k] = 1;
                end
            end
        end
    endtask

    task automatic cmp(input string p, input int k,
                       input logic [N-1:0] g, input logic [2:0] o,
                       input logic [W-1:0] b, input logic oe,
                       input logic t);
        logic [N-1:0] eg;
        logic [W-1:0] eb;
        eg = '0;
        eb = '0;
        if (m_own[k] >= 0) begin
            eg[m_own[k]] = 1'b1;
            eb = din[m_own[k]*W +: W];
        end
        chk({p, ".gnt"}, 32'(g), 32'(eg));
        chk({p, ".oe"}, 32'(oe), 32'(m_own[k] >= 0));
        chk({p, ".bus"}, 32'(b), 32'(eb));
        chk({p, ".timeout"}, 32'(t), 32'(m_to[k]));
        chk({p, ".onehot0"}, 32'($onehot0(g)), 32'd1);
        if (m_own[k] >= 0) begin
            chk({p, ".owner"}, 32'(o), 32'(m_own[k]));
        end else if (m_rstd[k]) begin
            chk({p, ".owner_rst"}, 32'(o), 32'd0);
        end
    endtask

    task automatic do_cycle();
        @(posedge clk);
        mstep(0, rst, req);
        mstep(1, rst, req);
        @(negedge clk);
        cmp("A", 0, gnt_a, owner_a, bus_a, oe_a, to_a);
        cmp("B", 1, gnt_b, owner_b, bus_b, oe_b, to_b);
    endtask

    initial begin
        int mode;
        int sel;
        for (int k = 0; k < 2; k++) begin
            m_own[k]  = -1;
            m_held[k] = 0;
            m_wait[k] = 0;
            m_ptr[k]  = 0;
            m_to[k]   = 1'b0;
            m_rstd[k] = 1'b0;
        end
        rst = 1'b1;
        req = '1;
        din = $urandom;
        repeat (2) do_cycle();
        rst = 1'b0;
        do_cycle();
        for (int seg = 0; seg < 24; seg++) begin
            mode = seg % 4;
            sel  = $urandom_range(0, N - 1);
            for (int c = 0; c < 150; c++) begin
                rst = 1'b0;
                din = $urandom;
                case (mode)
                    0: begin
                        req = N'($urandom);
                        rst = ($urandom_range(0, 49) == 0);
                    end
                    1: begin
                        for (int i = 0; i < N; i++) begin
                            if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
                        end
                        rst = ($urandom_range(0, 49) == 0);
                    end
                    2: begin
                        req = '1;
                        if (m_own[0] >= 0 && m_held[0] >= 3) begin
                            req[m_own[0]] = 1'b0;
                        end
                    end
                    default: begin
                        req = '0;
                        if ($urandom_range(0, 39) != 0) req[sel] = 1'b1;
                    end
                endcase
                do_cycle();
            end
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
